// File: rtl/sd_cmd_tx_gen.sv
// SD host CMD-line transmitter: serialises start/transmission bits, index, argument,
// a generated CRC and the end bit, then holds the line released for a minimum idle gap.
module sd_cmd_tx_gen #(
    parameter int unsigned          IdxWidth = 6,
    parameter int unsigned          ArgWidth = 32,
    parameter int unsigned          CrcWidth = 7,
    parameter logic [CrcWidth-1:0]  CrcPoly  = 7'h09,
    parameter int unsigned          MinGap   = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clk_en_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [IdxWidth-1:0] cmd_idx_i,
    input  logic [ArgWidth-1:0] cmd_arg_i,
    input  logic                abort_i,
    output logic                cmd_o,
    output logic                cmd_en_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                aborted_o
);
    localparam int unsigned H   = 2 + IdxWidth + ArgWidth;
    localparam int unsigned L   = H + CrcWidth + 1;
    localparam int unsigned BcW = $clog2(L + 1);
    localparam int unsigned GcW = (MinGap > 0) ? $clog2(MinGap + 1) : 1;

    localparam logic [BcW-1:0] BcHdr   = BcW'(H);
    localparam logic [BcW-1:0] BcCrc   = BcW'(H + CrcWidth);
    localparam logic [BcW-1:0] BcLen   = BcW'(L);
    localparam logic [GcW-1:0] GapLast = GcW'((MinGap > 0) ? MinGap - 1 : 0);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

    state_e                state_q, state_d;
    logic [BcW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [GcW-1:0]        gap_q, gap_d;
    logic [H-1:0]          sh_q, sh_d;
    logic [CrcWidth-1:0]   crc_q, crc_d;
    logic                  cmd_q, cmd_d;
    logic                  cmd_en_q, cmd_en_d;
    logic                  done_q, done_d;
    logic                  aborted_q, aborted_d;
    logic                  crc_fb;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            gap_q     <= '0;
            sh_q      <= '0;
            crc_q     <= '0;
            cmd_q     <= 1'b1;
            cmd_en_q  <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_q     <= gap_d;
            sh_q      <= sh_d;
            crc_q     <= crc_d;
            cmd_q     <= cmd_d;
            cmd_en_q  <= cmd_en_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_d     = gap_q;
        sh_d      = sh_q;
        crc_d     = crc_q;
        cmd_d     = cmd_q;
        cmd_en_d  = cmd_en_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        crc_fb    = sh_q[H-1] ^ crc_q[CrcWidth-1];

        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    sh_d      = {1'b0, 1'b1, cmd_idx_i, cmd_arg_i};
                    crc_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                // Abort is honoured on any clock, and wins over a simultaneous tick.
                if (abort_i) begin
                    cmd_d     = 1'b1;
                    cmd_en_d  = 1'b0;
                    aborted_d = 1'b1;
                    gap_d     = '0;
                    state_d   = GAP;
                end else if (clk_en_i) begin
                    if (bit_cnt_q == BcLen) begin
                        cmd_d    = 1'b1;
                        cmd_en_d = 1'b0;
                        done_d   = 1'b1;
                        gap_d    = '0;
                        state_d  = (MinGap == 0) ? IDLE : GAP;
                    end else begin
                        cmd_en_d  = 1'b1;
                        bit_cnt_d = bit_cnt_q + BcW'(1);
                        if (bit_cnt_q < BcHdr) begin
                            cmd_d = sh_q[H-1];
                            sh_d  = {sh_q[H-2:0], 1'b0};
                            crc_d = {crc_q[CrcWidth-2:0], 1'b0} ^ (crc_fb ? CrcPoly : '0);
                        end else if (bit_cnt_q < BcCrc) begin
                            cmd_d = crc_q[CrcWidth-1];
                            crc_d = {crc_q[CrcWidth-2:0], 1'b0};
                        end else begin
                            cmd_d = 1'b1;
                        end
                    end
                end
            end
            GAP: begin
                if (clk_en_i) begin
                    if (gap_q == GapLast) state_d = IDLE;
                    else                  gap_d   = gap_q + GcW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign cmd_o       = cmd_q;
    assign cmd_en_o    = cmd_en_q;
    assign done_o      = done_q;
    assign aborted_o   = aborted_q;
endmodule

// File: tb/tb_sd_cmd_tx_gen.sv
// Directed bench for sd_cmd_tx_gen: expected CMD bits are queued when a command is
// issued and popped as each bit appears on the line.
module tb_sd_cmd_tx_gen;
    logic        clk;
    logic        rst;
    logic        clk_en;
    logic        req_valid, req_ready_o;
    logic [5:0]  cmd_idx;
    logic [31:0] cmd_arg;
    logic        abort;
    logic        cmd_o, cmd_en_o, busy_o, done_o, aborted_o;

    logic        req_valid2, ready2;
    logic [5:0]  idx2;
    logic [15:0] arg2;
    logic        abort2;
    logic        cmd2, cmd_en2, busy2, done2, aborted2;

    int vectors = 0, miscompares = 0;
    logic q1[$], q2[$];
    logic last1, last2, tick_prev, prev_pulse, prev_en, in_gap;
    int   div, phase;
    int   en_cycles, done_cnt, ab_cnt, gap_ticks, busy_ticks, accepts, done2_cnt;

    sd_cmd_tx_gen dut (
        .clk_i(clk), .rst_i(rst), .clk_en_i(clk_en),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o),
        .cmd_idx_i(cmd_idx), .cmd_arg_i(cmd_arg), .abort_i(abort),
        .cmd_o(cmd_o), .cmd_en_o(cmd_en_o), .busy_o(busy_o),
        .done_o(done_o), .aborted_o(aborted_o)
    );

    sd_cmd_tx_gen #(.ArgWidth(16), .MinGap(0)) dut2 (
        .clk_i(clk), .rst_i(rst), .clk_en_i(clk_en),
        .req_valid_i(req_valid2), .req_ready_o(ready2),
        .cmd_idx_i(idx2), .cmd_arg_i(arg2), .abort_i(abort2),
        .cmd_o(cmd2), .cmd_en_o(cmd_en2), .busy_o(busy2),
        .done_o(done2), .aborted_o(aborted2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk1(input string tag, input logic got, input logic exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chkn(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [63:0] v, input int n);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = n - 1; i >= 0; i--) begin
            fb = v[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    task automatic push(input int which, input logic [63:0] f, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            if (which == 0) q1.push_back(f[i]);
            else            q2.push_back(f[i]);
        end
    endtask

    task automatic clr();
        en_cycles = 0; done_cnt = 0; ab_cnt = 0; gap_ticks = 0;
        busy_ticks = 0; accepts = 0; done2_cnt = 0;
    endtask

    // One clock: count a handshake about to happen, sample at negedge, drive next tick.
    task automatic step();
        logic e;
        if (req_valid && req_ready_o) begin
            accepts++;
            chk1("hs_in_idle", busy_o, 1'b0);
        end
        @(negedge clk);
        if (cmd_en_o && tick_prev) begin
            if (q1.size() == 0) chkn("sb1_underflow", q1.size(), 1);
            else begin
                e = q1.pop_front();
                chk1("bit", cmd_o, e);
                last1 = e;
            end
        end else if (cmd_en_o) chk1("hold", cmd_o, last1);
        if (cmd_en2 && tick_prev) begin
            if (q2.size() == 0) chkn("sb2_underflow", q2.size(), 1);
            else begin
                e = q2.pop_front();
                chk1("bit2", cmd2, e);
                last2 = e;
            end
        end else if (cmd_en2) chk1("hold2", cmd2, last2);
        if (done_o || aborted_o) begin
            chk1("done_abort_excl", done_o & aborted_o, 1'b0);
            chk1("pulse_one_cycle", prev_pulse, 1'b0);
            in_gap = 1'b1;
        end
        if (done_o) begin
            chk1("done_after_last_bit", prev_en, 1'b1);
            done_cnt++;
        end
        if (aborted_o) ab_cnt++;
        if (done2) begin
            chk1("w2_excl", done2 & aborted2, 1'b0);
            done2_cnt++;
        end
        prev_pulse = done_o | aborted_o;
        prev_en    = cmd_en_o;
        if (!busy_o) in_gap = 1'b0;
        if (cmd_en_o) en_cycles++;
        phase     = (phase + 1) % div;
        clk_en    = (phase == 0);
        tick_prev = clk_en;
        if (clk_en && in_gap) gap_ticks++;
        if (clk_en && busy_o) busy_ticks++;
    endtask

    task automatic issue(input int which, input logic [5:0] idx, input logic [31:0] arg);
        int n;
        n = 0;
        if (which == 0) begin
            cmd_idx = idx; cmd_arg = arg; req_valid = 1'b1;
            while (!req_ready_o && n < 2000) begin step(); n++; end
            chk1("issue_ready", req_ready_o, 1'b1);
        end else begin
            idx2 = idx; arg2 = arg[15:0]; req_valid2 = 1'b1;
            while (!ready2 && n < 2000) begin step(); n++; end
            chk1("issue_ready2", ready2, 1'b1);
        end
        step();
        req_valid = 1'b0; req_valid2 = 1'b0;
        cmd_idx = '0; cmd_arg = '0; idx2 = '0; arg2 = '0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready_o && n < 2000) begin step(); n++; end
        chk1("wait_ready", req_ready_o, 1'b1);
    endtask

    initial begin
        logic [5:0]  ri;
        logic [15:0] ra;
        logic [63:0] h, f;
        int n;
        rst = 1'b1; clk_en = 1'b1; req_valid = 1'b0; req_valid2 = 1'b0;
        cmd_idx = '0; cmd_arg = '0; idx2 = '0; arg2 = '0; abort = 1'b0; abort2 = 1'b0;
        div = 1; phase = 0; tick_prev = 1'b0; prev_pulse = 1'b0; prev_en = 1'b0;
        in_gap = 1'b0; last1 = 1'b1; last2 = 1'b1;
        clr();
        step(); step();
        chk1("rst_cmd", cmd_o, 1'b1);
        chk1("rst_cmd_en", cmd_en_o, 1'b0);
        chk1("rst_ready", req_ready_o, 1'b1);
        chk1("rst_busy", busy_o, 1'b0);
        chk1("rst_done", done_o, 1'b0);
        chk1("rst_aborted", aborted_o, 1'b0);
        chk1("rst_ready2", ready2, 1'b1);
        rst = 1'b0;
        step();

        // CMD0, tick every cycle
        clr();
        push(0, 64'h0000_4000_0000_0095, 48);
        issue(0, 6'd0, 32'h0);
        wait_ready();
        chkn("t1_en_cycles", en_cycles, 48);
        chkn("t1_done", done_cnt, 1);
        chkn("t1_gap_ticks", gap_ticks, 8);
        chkn("t1_sb_empty", q1.size(), 0);

        // CMD8, tick 1-in-4
        div = 4; phase = 0;
        clr();
        push(0, 64'h0000_4800_0001_AA87, 48);
        issue(0, 6'd8, 32'h0000_01AA);
        wait_ready();
        chkn("t2_en_cycles", en_cycles, 4 * 48);
        chkn("t2_busy_ticks", busy_ticks, 48 + 1 + 8);
        chkn("t2_done", done_cnt, 1);
        chkn("t2_gap_ticks", gap_ticks, 8);
        chkn("t2_sb_empty", q1.size(), 0);

        // Back-to-back CMD17 with req_valid held
        div = 1; phase = 0;
        clr();
        push(0, 64'h0000_5100_0000_0055, 48);
        push(0, 64'h0000_5100_0000_0055, 48);
        cmd_idx = 6'd17; cmd_arg = 32'h0; req_valid = 1'b1;
        n = 0;
        while (accepts < 2 && n < 500) begin step(); n++; end
        req_valid = 1'b0;
        chkn("b2b_accepts", accepts, 2);
        chkn("b2b_gap_ticks", gap_ticks, 8);
        wait_ready();
        chkn("b2b_done", done_cnt, 2);
        chkn("b2b_sb_empty", q1.size(), 0);

        // Abort after 20 bits
        clr();
        push(0, 64'h0000_4800_0001_AA87, 48);
        issue(0, 6'd8, 32'h0000_01AA);
        n = 0;
        while (q1.size() > 28 && n < 200) begin step(); n++; end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk1("ab_cmd_en", cmd_en_o, 1'b0);
        chk1("ab_cmd", cmd_o, 1'b1);
        chk1("ab_pulse", aborted_o, 1'b1);
        chk1("ab_no_done", done_o, 1'b0);
        chkn("ab_bits_sent", 48 - q1.size(), 20);
        q1.delete();
        step();
        chk1("ab_pulse_end", aborted_o, 1'b0);
        wait_ready();
        chkn("ab_count", ab_cnt, 1);
        chkn("ab_done_count", done_cnt, 0);
        chkn("ab_gap_ticks", gap_ticks, 8);

        // Asynchronous reset inside the CRC field
        clr();
        push(0, 64'h0000_4000_0000_0095, 48);
        issue(0, 6'd0, 32'h0);
        n = 0;
        while (q1.size() > 4 && n < 200) begin step(); n++; end
        #2 rst = 1'b1;
        #1;
        chk1("arst_cmd_en", cmd_en_o, 1'b0);
        chk1("arst_cmd", cmd_o, 1'b1);
        chk1("arst_ready", req_ready_o, 1'b1);
        chk1("arst_busy", busy_o, 1'b0);
        q1.delete();
        step(); step();
        rst = 1'b0;
        step();
        clr();
        push(0, 64'h0000_4000_0000_0095, 48);
        issue(0, 6'd0, 32'h0);
        wait_ready();
        chkn("arst_done", done_cnt, 1);
        chkn("arst_sb_empty", q1.size(), 0);

        // 16-bit argument, no gap
        clr();
        for (int k = 0; k < 3; k++) begin
            ri = 6'($urandom_range(0, 63));
            ra = 16'($urandom);
            h  = {40'h0, 2'b01, ri, ra};
            f  = {32'h0, h[23:0], crc7(h, 24), 1'b1};
            push(1, f, 32);
            issue(1, ri, {16'h0, ra});
            n = 0;
            while (done2_cnt == k && n < 200) begin step(); n++; end
            chkn("w2_done", done2_cnt, k + 1);
            step();
            chk1("w2_ready_after_done", ready2, 1'b1);
            chk1("w2_idle", busy2, 1'b0);
            chkn("w2_sb_empty", q2.size(), 0);
        end

        chkn("final_sb1_empty", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
